mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single physical memory port between the instruction-side cache (I) and the data-side cache (D) of the pipelined core. It sits between the two caches and main memory. It serialises one line transaction at a time, latches the winner's command, and returns a one-cycle response pulse with registered read data to the winner only. Pipeline stalls (read_intr_stall, mem_access_stall) are produced by the caches while they wait on this block's responses.

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester line arbiter: serialises I-cache fetches and D-cache
// reads/write-backs onto one memory port, alternating under contention.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SERVE_I = 3'd1;
  localparam logic [2:0] SERVE_D = 3'd2;
  localparam logic [2:0] RESP_I  = 3'd3;
  localparam logic [2:0] RESP_D  = 3'd4;

  logic [2:0] state;
  logic       last_grant;
  logic       i_pend;
  logic       d_pend;
  logic       grant_d;

  // D wins contention unless it won the previous grant.
  assign i_pend  = i_read;
  assign d_pend  = d_read | d_write;
  assign grant_d = d_pend & (~i_pend | ~last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_resp      <= 1'b0;
      d_resp      <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            // read+write together is treated as a write-back
            mem_write   <= d_write;
            mem_read    <= ~d_write;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            last_grant  <= 1'b1;
            state       <= SERVE_D;
          end else if (i_pend) begin
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= i_address;
            last_grant  <= 1'b0;
            state       <= SERVE_I;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_rdata   <= mem_rdata;
            i_resp    <= 1'b1;
            state     <= RESP_I;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_rdata   <= mem_rdata;
            d_resp    <= 1'b1;
            state     <= RESP_D;
          end
        end
        RESP_I, RESP_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory responses are driven by hand and
// every expectation is a hand-computed constant.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read, d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;

  logic [255:0] dat_a, dat_b, dat_c, dat_k;

  mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reply(input logic [255:0] data);
    mem_rdata = data;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    dat_a = {8{32'hAAAA_0001}};
    dat_b = {8{32'hBBBB_0002}};
    dat_c = {8{32'hCCCC_0003}};
    rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    tick(); tick();
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_resp", {i_resp, d_resp}, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_rdata", i_rdata | d_rdata | mem_wdata, 0);
    rst = 1'b0;
    tick();

    // Lone I read, memory answers after 3 command cycles
    i_read = 1; i_address = 32'h0000_0040;
    check("i1_pre_cmd", mem_read, 0);
    tick();
    check("i1_cmd", mem_read, 1);
    check("i1_addr", mem_address, 32'h40);
    check("i1_nowrite", mem_write, 0);
    tick();
    check("i1_cmd_c2", mem_read, 1);
    tick();
    check("i1_cmd_c3", mem_read, 1);
    check("i1_noresp_yet", i_resp, 0);
    reply(dat_a);
    check("i1_resp", i_resp, 1);
    check("i1_rdata", i_rdata, dat_a);
    check("i1_cmd_drop", mem_read, 0);
    check("i1_no_dresp", d_resp, 0);
    i_read = 0;
    tick();
    check("i1_resp_pulse", i_resp, 0);
    tick();
    check("i1_idle_cmd", mem_read, 0);

    // Lone D write-back
    d_write = 1; d_address = 32'h0000_0080; d_wdata = dat_b;
    tick();
    check("d1_write", mem_write, 1);
    check("d1_noread", mem_read, 0);
    check("d1_wdata", mem_wdata, dat_b);
    check("d1_addr", mem_address, 32'h80);
    tick();
    check("d1_hold", {mem_read, mem_write}, 2'b01);
    reply(dat_c);
    check("d1_resp", d_resp, 1);
    check("d1_no_iresp", i_resp, 0);
    check("d1_cmd_drop", mem_write, 0);
    d_write = 0;
    tick();
    check("d1_resp_pulse", d_resp, 0);

    // Contention from reset: D, then I
    rst = 1; tick(); rst = 0;
    d_read = 1; d_address = 32'h0000_0100; i_read = 1; i_address = 32'h0000_0200;
    tick();
    check("c1_grant_d", mem_address, 32'h100);
    check("c1_read", mem_read, 1);
    reply(dat_a);
    check("c1_dresp", {i_resp, d_resp}, 2'b01);
    check("c1_drdata", d_rdata, dat_a);
    d_read = 0;
    tick();
    tick();
    check("c2_grant_i", mem_address, 32'h200);
    reply(dat_b);
    check("c2_iresp", {i_resp, d_resp}, 2'b10);
    check("c2_irdata", i_rdata, dat_b);
    d_read = 1;
    tick();

    // Both held continuously: D,I,D,I,D,I
    for (int k = 0; k < 6; k++) begin
      logic is_d;
      is_d  = (k % 2 == 0);
      dat_k = {8{32'(32'h5000_0000 + k)}};
      tick();
      check($sformatf("alt%0d_addr", k), mem_address, is_d ? 32'h100 : 32'h200);
      check($sformatf("alt%0d_read", k), mem_read, 1);
      reply(dat_k);
      check($sformatf("alt%0d_resp", k), {i_resp, d_resp}, is_d ? 2'b01 : 2'b10);
      check($sformatf("alt%0d_rdata", k), is_d ? d_rdata : i_rdata, dat_k);
      tick();
    end

    // Reset two cycles into SERVE_D (last grant was I, so D wins)
    d_address = 32'h0000_0300; i_address = 32'h0000_0400;
    tick();
    check("r_grant_d", mem_address, 32'h300);
    tick();
    rst = 1;
    #1;
    check("r_cmd_clear", {mem_read, mem_write}, 0);
    check("r_addr_clear", mem_address, 0);
    check("r_rdata_clear", i_rdata | d_rdata, 0);
    check("r_resp_clear", {i_resp, d_resp}, 0);
    d_read = 0;
    tick();
    rst = 0;
    tick();
    check("r_i_grant", mem_address, 32'h400);
    check("r_i_read", mem_read, 1);
    reply(dat_c);
    check("r_iresp", {i_resp, d_resp}, 2'b10);
    i_read = 0;
    tick();

    // Read+write together is a write; stray mem_resp in IDLE is ignored
    d_read = 1; d_write = 1; d_address = 32'h0000_0500; d_wdata = dat_c;
    tick();
    check("rw_cmd", {mem_read, mem_write}, 2'b01);
    check("rw_wdata", mem_wdata, dat_c);
    reply(dat_a);
    check("rw_dresp", d_resp, 1);
    d_read = 0; d_write = 0;
    tick();
    reply(dat_b);
    check("stray_resp", {i_resp, d_resp}, 0);
    check("stray_cmd", {mem_read, mem_write}, 0);
    tick();
    check("stray_resp2", {i_resp, d_resp}, 0);
    i_read = 1; i_address = 32'h0000_0600;
    tick();
    check("stray_then_grant", mem_address, 32'h600);
    check("stray_then_read", mem_read, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
